// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch stage. Accepts one fetch request
//   (byte PC) at a time and returns the instruction word after LATENCY cycles,
//   counted from the cycle the request is presented. While a fetch is in
//   flight, busy is high so the hazard logic can stall PC writes. A flush
//   cancels the in-flight fetch (branch/J/JR redirect). A request presented
//   together with the flush is accepted in the same cycle, so a redirect adds
//   no bubble. A load port writes program words at any time.
//
// Parameters
//   ADDR_W   word-address width; DEPTH = 2**ADDR_W words
//   DATA_W   instruction width
//   LATENCY  request-to-response latency in cycles, 1..8
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset (memory contents are kept)
//   req, addr  fetch request and byte PC; sampled only while busy=0
//   flush      cancel the in-flight fetch
//   busy       fetch in flight; new requests are not taken
//   rvalid     one-cycle pulse qualifying rdata/rerr
//   rdata      fetched instruction, 0 on error; holds between responses
//   rerr       misaligned or out-of-range PC
//   load_en, load_addr, load_data   program-load write port
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic              flush,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A PC is bad if it is not word aligned or points beyond the memory.
  function automatic logic addr_error(input logic [31:0] a);
    logic [31:0] hi_v;
    hi_v = a >> (ADDR_W + 2);
    addr_error = (a[1:0] != 2'b00) || (hi_v != 32'd0);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] waddr_r;
  logic              err_r;

  logic [ADDR_W-1:0] req_waddr_s;
  logic              req_err_s;

  // Decode the incoming PC into a word address and an error flag.
  always_comb begin
    req_waddr_s = addr[ADDR_W+1:2];
    req_err_s   = addr_error(addr);
  end

  // Program-load write port; no reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Fetch FSM with registered outputs. The memory is read with non-blocking
  // semantics, so a load on the response edge returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      waddr_r <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
      busy    <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= {DATA_W{1'b0}};
      rerr    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // flush is meaningless here; a request is taken as usual.
          if (req) begin
            cnt_r   <= CNT_INIT;
            waddr_r <= req_waddr_s;
            err_r   <= req_err_s;
            if (LATENCY == 1) begin
              // Single-cycle latency: the acceptance edge is the response edge.
              rvalid <= 1'b1;
              rerr   <= req_err_s;
              rdata  <= req_err_s ? {DATA_W{1'b0}} : mem_r[req_waddr_s];
            end else begin
              state_r <= ST_WAIT;
              busy    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            // Redirect: drop the old fetch; a new request restarts the count.
            if (req) begin
              cnt_r   <= CNT_INIT;
              waddr_r <= req_waddr_s;
              err_r   <= req_err_s;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end else if (cnt_r == 4'd1) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            rvalid  <= 1'b1;
            rerr    <= err_r;
            rdata   <= err_r ? {DATA_W{1'b0}} : mem_r[waddr_r];
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
